// File: rtl/dldo_pkg.sv
// Shared definitions for the digital LDO loop controller and the pass-array model.
// Contents:
//   dldo_state_t  loop state encoding (HOLD/COARSE/FINE/LOCK)
//   DLDO_*        default loop parameters
//   dldo_clog2    ceil(log2(value)), never less than 1
package dldo_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_COARSE = 2'd1,
        ST_FINE   = 2'd2,
        ST_LOCK   = 2'd3
    } dldo_state_t;

    localparam int DLDO_PASS_NUM     = 10;
    localparam int DLDO_COARSE_STEP  = 4;
    localparam int DLDO_LOCK_TOGGLES = 4;
    localparam int DLDO_UNLOCK_RUN   = 3;
    localparam int DLDO_COARSE_RUN   = 4;

    function automatic int dldo_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/dldo_therm_decoder.sv
// Binary-to-thermometer decoder for the pass-device gate bus. Purely combinational.
// Ports:
//   code  in   binary count of devices to enable (0..PASS_NUM)
//   out   out  thermometer gate enables, out[i] = (i < code)
module dldo_therm_decoder
    import dldo_pkg::*;
#(
    parameter  int PASS_NUM = DLDO_PASS_NUM,
    localparam int CNT_W    = dldo_clog2(PASS_NUM + 1)
) (
    input  logic [CNT_W-1:0]    code,
    output logic [PASS_NUM-1:0] out
);

    for (genvar i = 0; i < PASS_NUM; i++) begin : g_bit
        assign out[i] = (code > CNT_W'(i));
    end

endmodule

// File: rtl/dldo_loop_controller.sv
// Coarse/fine/lock tracking loop driving the digital LDO pass-device array.
// Ports:
//   clk      in   loop clock
//   rst      in   asynchronous active-low reset
//   en       in   loop enable (synchronous)
//   comp_in  in   comparator, asynchronous; 1 = VOUT low (add drive), 0 = VOUT high
//   out      out  thermometer gate enables
//   code     out  binary count of enabled devices
//   state    out  loop state (see table)
//   locked   out  high in LOCK
//   sat_hi   out  code at PASS_NUM
//   sat_lo   out  code at 0
//
// state  | meaning
// HOLD   | loop idle, code frozen
// COARSE | large steps toward the target until the comparator reverses
// FINE   | unit steps; counts reversals (lock) and same-direction runs (recoarse)
// LOCK   | code frozen; a long same-direction run drops back to FINE
module dldo_loop_controller
    import dldo_pkg::*;
#(
    parameter  int PASS_NUM     = DLDO_PASS_NUM,
    parameter  int COARSE_STEP  = DLDO_COARSE_STEP,
    parameter  int LOCK_TOGGLES = DLDO_LOCK_TOGGLES,
    parameter  int UNLOCK_RUN   = DLDO_UNLOCK_RUN,
    parameter  int COARSE_RUN   = DLDO_COARSE_RUN,
    localparam int CNT_W        = dldo_clog2(PASS_NUM + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                comp_in,
    output logic [PASS_NUM-1:0] out,
    output logic [CNT_W-1:0]    code,
    output logic [1:0]          state,
    output logic                locked,
    output logic                sat_hi,
    output logic                sat_lo
);

    localparam int RUN_MAX_A = (LOCK_TOGGLES > UNLOCK_RUN) ? LOCK_TOGGLES : UNLOCK_RUN;
    localparam int RUN_MAX   = (RUN_MAX_A > COARSE_RUN) ? RUN_MAX_A : COARSE_RUN;
    localparam int RUN_W     = dldo_clog2(RUN_MAX + 1);
    localparam int EXT_W     = CNT_W + 1;

    localparam logic [EXT_W-1:0] CODE_MAX  = EXT_W'(PASS_NUM);
    localparam logic [EXT_W-1:0] STEP_C    = EXT_W'(COARSE_STEP);
    localparam logic [EXT_W-1:0] STEP_F    = EXT_W'(1);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [RUN_W-1:0] LOCK_C    = RUN_W'(LOCK_TOGGLES);
    localparam logic [RUN_W-1:0] UNLOCK_C  = RUN_W'(UNLOCK_RUN);
    localparam logic [RUN_W-1:0] RECOARSE_C = RUN_W'(COARSE_RUN);

    logic              sync_1, sync_2;
    logic              prev_dir, prev_valid;
    logic [CNT_W-1:0]  code_q, code_d;
    dldo_state_t       state_q, state_d;
    logic [RUN_W-1:0]  run_q, run_d, tog_q, tog_d;
    logic [RUN_W-1:0]  run_inc, tog_inc, lock_run;
    logic              dir, reversal;

    assign dir      = sync_2;
    assign reversal = prev_valid & (dir != prev_dir);
    assign run_inc  = run_q + RUN_ONE;
    assign tog_inc  = tog_q + RUN_ONE;
    assign lock_run = reversal ? RUN_ONE : run_inc;

    // Extra headroom bit keeps the upward sum from wrapping before the clamp.
    function automatic logic [CNT_W-1:0] step_code(input logic [CNT_W-1:0] cur,
                                                   input logic             up,
                                                   input logic [EXT_W-1:0] step);
        logic [EXT_W-1:0] cur_ext;
        logic [EXT_W-1:0] res;
        cur_ext = {1'b0, cur};
        if (up) begin
            res = (cur_ext + step > CODE_MAX) ? CODE_MAX : cur_ext + step;
        end else begin
            res = (cur_ext < step) ? '0 : cur_ext - step;
        end
        return res[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_1     <= 1'b0;
            sync_2     <= 1'b0;
            prev_dir   <= 1'b0;
            prev_valid <= 1'b0;
            code_q     <= CNT_W'(PASS_NUM);
            state_q    <= ST_HOLD;
            run_q      <= '0;
            tog_q      <= '0;
        end else begin
            sync_1     <= comp_in;
            sync_2     <= sync_1;
            if (en) begin
                prev_dir   <= dir;
                prev_valid <= 1'b1;
            end else begin
                prev_valid <= 1'b0;
            end
            code_q     <= code_d;
            state_q    <= state_d;
            run_q      <= run_d;
            tog_q      <= tog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        run_d   = run_q;
        tog_d   = tog_q;
        if (!en) begin
            state_d = ST_HOLD;
            run_d   = '0;
            tog_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    state_d = ST_COARSE;
                    run_d   = '0;
                    tog_d   = '0;
                end
                ST_COARSE: begin
                    run_d = '0;
                    tog_d = '0;
                    if (reversal) begin
                        state_d = ST_FINE;
                        code_d  = step_code(code_q, dir, STEP_F);
                    end else begin
                        code_d  = step_code(code_q, dir, STEP_C);
                    end
                end
                ST_FINE: begin
                    code_d = step_code(code_q, dir, STEP_F);
                    if (reversal) begin
                        if (tog_inc == LOCK_C) begin
                            state_d = ST_LOCK;
                            run_d   = '0;
                            tog_d   = '0;
                        end else begin
                            run_d   = RUN_ONE;
                            tog_d   = tog_inc;
                        end
                    end else begin
                        if (run_inc == RECOARSE_C) begin
                            state_d = ST_COARSE;
                            run_d   = '0;
                        end else begin
                            run_d   = run_inc;
                        end
                        tog_d = '0;
                    end
                end
                ST_LOCK: begin
                    tog_d = '0;
                    if (lock_run == UNLOCK_C) begin
                        state_d = ST_FINE;
                        run_d   = '0;
                    end else begin
                        run_d   = lock_run;
                    end
                end
                default: state_d = ST_HOLD;
            endcase
        end
    end

    always_comb begin
        locked = (state_q == ST_LOCK);
        sat_hi = (code_q == CNT_W'(PASS_NUM));
        sat_lo = (code_q == '0);
    end

    assign state = state_q;
    assign code  = code_q;

    dldo_therm_decoder #(
        .PASS_NUM(PASS_NUM)
    ) u_therm (
        .code(code_q),
        .out (out)
    );

endmodule

// File: tb/tb_dldo_loop_controller.sv
module tb_dldo_loop_controller;

    localparam int PN = 10;
    localparam int CS = 4;
    localparam int LT = 4;
    localparam int UR = 3;
    localparam int CR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en = 1'b0;
    logic          comp_in = 1'b0;
    logic [PN-1:0] out;
    logic [3:0]    code;
    logic [1:0]    state;
    logic          locked, sat_hi, sat_lo;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // behavioural model: state as 0..3, code as plain integer, direction history as a 2-deep list
    int m_code  = PN;
    int m_state = 0;
    int m_prev  = -1;
    int m_run   = 0;
    int m_tog   = 0;
    int m_hist[2] = '{0, 0};

    dldo_loop_controller dut (
        .clk(clk), .rst(rst), .en(en), .comp_in(comp_in),
        .out(out), .code(code), .state(state), .locked(locked),
        .sat_hi(sat_hi), .sat_lo(sat_lo)
    );

    initial forever #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > PN) ? PN : v);
    endfunction

    task automatic model_step();
        int d, sgn;
        bit rev;
        if (!rst) begin
            m_code = PN; m_state = 0; m_prev = -1; m_run = 0; m_tog = 0;
            m_hist = '{0, 0};
        end else begin
            d   = m_hist[1];
            rev = (m_prev != -1) && (d != m_prev);
            m_hist[1] = m_hist[0];
            m_hist[0] = int'(comp_in);
            sgn = d ? 1 : -1;
            if (!en) begin
                m_state = 0; m_prev = -1; m_run = 0; m_tog = 0;
            end else begin
                case (m_state)
                    0: m_state = 1;
                    1: begin
                        if (rev) begin
                            m_code  = clamp(m_code + sgn);
                            m_state = 2;
                        end else begin
                            m_code = clamp(m_code + sgn * CS);
                        end
                    end
                    2: begin
                        m_code = clamp(m_code + sgn);
                        if (rev) begin
                            m_tog = m_tog + 1;
                            m_run = 1;
                            if (m_tog == LT) begin
                                m_state = 3; m_tog = 0; m_run = 0;
                            end
                        end else begin
                            m_run = m_run + 1;
                            m_tog = 0;
                            if (m_run == CR) begin
                                m_state = 1; m_run = 0;
                            end
                        end
                    end
                    default: begin
                        m_run = rev ? 1 : m_run + 1;
                        if (m_run == UR) begin
                            m_state = 2; m_run = 0;
                        end
                    end
                endcase
                m_prev = d;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("code", int'(code), m_code);
            chk("state", int'(state), m_state);
            chk("out", int'(out), ((1 << m_code) - 1));
            chk("locked", int'(locked), int'(m_state == 3));
            chk("sat_hi", int'(sat_hi), int'(m_code == PN));
            chk("sat_lo", int'(sat_lo), int'(m_code == 0));
        end
    end

    task automatic cyc(input logic e, input logic c);
        en = e;
        comp_in = c;
        @(negedge clk);
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b0;
        #1;
        chk("async_rst_out", int'(out), 'h3FF);
        chk("async_rst_code", int'(code), PN);
        chk("async_rst_state", int'(state), 0);
        #1 rst = 1'b1;
    endtask

    int a_code[6] = '{10, 6, 2, 0, 0, 0};
    int b_dir[19]  = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    int b_st[19]   = '{1, 1, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1};
    int b_code[19] = '{10, 6, 7, 6, 5, 6, 5, 6, 5, 5, 5, 5, 5, 5, 6, 7, 8, 9, 10};

    initial begin
        int mode;
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_out", int'(out), 'h3FF);
        chk("rst_code", int'(code), 10);
        chk("rst_state", int'(state), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_sat_hi", int'(sat_hi), 1);
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        chk("idle_state", int'(state), 0);
        chk("idle_code", int'(code), 10);

        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, 1'b0);
            chk("descent_state", int'(state), 1);
            chk("descent_code", int'(code), a_code[k]);
        end
        chk("descent_sat_lo", int'(sat_lo), 1);
        cyc(1'b0, 1'b0);
        chk("disable_state", int'(state), 0);
        chk("disable_code", int'(code), 0);
        rst_pulse();
        @(negedge clk);
        cyc(1'b0, 1'b0);

        for (int k = 0; k < 19; k++) begin
            cyc(1'b1, (k + 2 < 19) ? b_dir[k + 2][0] : 1'b1);
            chk("seq_state", int'(state), b_st[k]);
            chk("seq_code", int'(code), b_code[k]);
            chk("seq_locked", int'(locked), int'(b_st[k] == 3));
        end
        chk("recoarse_sat_hi", int'(sat_hi), 1);
        cyc(1'b0, 1'b1);
        chk("drop_en_state", int'(state), 0);
        chk("drop_en_code", int'(code), 10);
        rst_pulse();
        @(negedge clk);

        mode = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 150 == 0) mode = $urandom_range(0, 2);
            en = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
            case (mode)
                0: comp_in = $urandom_range(0, 1) != 0;
                1: comp_in = ($urandom_range(0, 9) < 9) ? ~comp_in : comp_in;
                default: comp_in = ($urandom_range(0, 19) == 0) ? ~comp_in : comp_in;
            endcase
            if ($urandom_range(0, 599) == 0) rst_pulse();
            @(negedge clk);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
